seq_alu: RTL
============

Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the combinational datapath ALU.
- Accepts one operation per start pulse, latches operands and options, and produces a 2*WIDTH-bit result with a start/busy/done handshake.
- MUL and DIV run iteratively, one bit per cycle. All other ops complete in one cycle.
- Sits between the register-file read stage and the hi/lo result registers of the datapath.

Parameters:
- WIDTH, 32, operand width in bits; power of two, >= 8.
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- aluop  in  4  operation code, latched with start.
- a  in  WIDTH  operand A, latched with start.
- b  in  WIDTH  operand B, latched with start.
- output_inverted  in  1  invert the raw 2*WIDTH result; latched with start.
- output_inc  in  1  add 1 after the optional inversion; latched with start.
- busy  out  1  operation in flight; start is ignored while high.
- done  out  1  one-cycle pulse; result valid.
- div_by_zero  out  1  valid with done; set when a DIV had b==0.
- res_high  out  WIDTH  upper result word; held until the next done.
- res_low  out  WIDTH  lower result word; held until the next done.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy, done, div_by_zero, res_high, res_low = 0; iteration counter = 0.
- States:
  - IDLE: start=1 latches a, b, aluop and options, then goes to CALC if aluop is MUL or DIV, otherwise to FIN.
  - CALC: runs exactly WIDTH cycles, counter 0..WIDTH-1, then goes to FIN.
  - FIN: registers the post-processed result, pulses done=1, and goes to IDLE.
- busy = 1 in CALC and FIN.
- Back-to-back: the cycle in which done=1 is FIN; the next start is sampled in IDLE on the following cycle.
- Latency from the start-sampling edge to done=1: 1 cycle for single-cycle ops, WIDTH+1 cycles for MUL/DIV.
- Opcodes and raw results {high, low}:
  - 0 ADD: {carry-out zero-extended, a+b}.
  - 1 SUB: {all-ones if borrow (a<b unsigned) else 0, a-b}.
  - 2 MUL: unsigned {a*b}, shift-add.
  - 3 DIV: unsigned restoring, {remainder, quotient}.
  - 4 AND, 5 OR, 6 XOR: {0, a op b}.
  - 7 CLO: {0, count of leading ones of a}.
  - 8 CLZ: {0, count of leading zeros of a}. CLZ(0) = WIDTH.
  - 9 SLL, 10 SRL, 11 SRA: {0, shifted a}; shift amount = b[SHW-1:0].
  - 12 ROL: {0, a rotated left by b[SHW-1:0]}.
  - 13-15: {0, 0}.
- DIV with b==0: quotient = all-ones, remainder = a, div_by_zero=1. Still takes WIDTH+1 cycles.
- div_by_zero is cleared at the next start.
- Post-processing, applied to every op in FIN: result = (inv ? ~raw : raw) + inc, computed modulo 2^(2*WIDTH). Carry-out is discarded.
- start while busy=1 is ignored: no latch, no effect on the in-flight op.
- Inputs changing during CALC have no effect, because operands are latched.
- Reset asserted mid-operation aborts the op: outputs return to their reset values and no done is issued.

Decomposition:
- Package seq_alu_pkg:
  - localparams for the 16 opcode encodings above;
  - state encoding IDLE/CALC/FIN (2-bit);
  - function clz_count(WIDTH-bit) shared by CLO/CLZ.
- Sub-module seq_alu_muldiv:
  - iterative shift-add multiplier and restoring divider sharing one 2*WIDTH accumulator and the counter;
  - interface: go, is_div, a, b, acc_out, last.
- Top-level seq_alu holds the FSM, the single-cycle ops mux, the post-processing adder and the result registers.

Test Plan (WIDTH=32):
- ADD a=FFFFFFFF, b=00000001 -> done 1 cycle after start; res_high=00000001, res_low=00000000.
- SUB a=3, b=5 -> res_high=FFFFFFFF, res_low=FFFFFFFE. Then ADD a=5, b=0 with output_inverted=1 and output_inc=1 -> res_high=FFFFFFFF, res_low=FFFFFFFB.
- MUL a=FFFFFFFF, b=FFFFFFFF -> done exactly 33 cycles after start; res_high=FFFFFFFE, res_low=00000001; busy=1 for those 33 cycles.
- DIV a=100, b=7 -> res_low=14, res_high=2, div_by_zero=0. DIV a=1234, b=0 -> res_low=FFFFFFFF, res_high=1234, div_by_zero=1.
- CLZ a=0 -> res_low=32. CLO a=F0000000 -> res_low=4. ROL a=80000001, b=1 -> res_low=00000003. SRA a=80000000, b=33 -> res_low=C0000000 (amount 1).
- Start DIV, pulse start with ADD at cycle 5 -> ignored; the DIV result is correct. Then assert rst=0 at cycle 10 of a new MUL -> busy=0, done=0, results=0 immediately; no done after rst is released.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared opcode encodings, FSM state type and leading-zero helper for seq_alu.
package seq_alu_pkg;

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpSub = 4'd1;
  localparam logic [3:0] OpMul = 4'd2;
  localparam logic [3:0] OpDiv = 4'd3;
  localparam logic [3:0] OpAnd = 4'd4;
  localparam logic [3:0] OpOr  = 4'd5;
  localparam logic [3:0] OpXor = 4'd6;
  localparam logic [3:0] OpClo = 4'd7;
  localparam logic [3:0] OpClz = 4'd8;
  localparam logic [3:0] OpSll = 4'd9;
  localparam logic [3:0] OpSrl = 4'd10;
  localparam logic [3:0] OpSra = 4'd11;
  localparam logic [3:0] OpRol = 4'd12;
  localparam logic [3:0] OpRs0 = 4'd13;
  localparam logic [3:0] OpRs1 = 4'd14;
  localparam logic [3:0] OpRs2 = 4'd15;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFin  = 2'd2
  } state_e;

  // Widest operand the counting helper can accept; callers zero-extend.
  localparam int unsigned ClzMaxWidth = 256;

  // Leading zeros of the low `width` bits of v. CLO is clz_count(~a).
  function automatic int unsigned clz_count(input logic [ClzMaxWidth-1:0] v,
                                            input int unsigned width);
    int unsigned cnt;
    logic        found;
    cnt   = 0;
    found = 1'b0;
    for (int i = ClzMaxWidth - 1; i >= 0; i--) begin
      if ((i < int'(width)) && !found) begin
        if (v[i]) found = 1'b1;
        else      cnt   = cnt + 1;
      end
    end
    return cnt;
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned shift-add multiplier and restoring divider, one bit per
// cycle, sharing one 2*WIDTH accumulator and iteration counter.
// Multiply: acc = {partial product, multiplier}; divide: acc = {remainder, quotient}.
module seq_alu_muldiv
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc_out,
  output logic               last
);

  localparam int unsigned W2 = 2 * WIDTH;

  logic [W2-1:0]    r_acc;
  logic [WIDTH-1:0] r_opnd;
  logic [SHW-1:0]   r_cnt;
  logic             r_run;
  logic             r_is_div;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_rsh;
  logic [WIDTH:0]   w_diff;
  logic [W2-1:0]    w_step;

  // One iteration of the selected algorithm on the current accumulator.
  always_comb begin
    w_sum  = {1'b0, r_acc[W2-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_rsh  = {r_acc[W2-1:WIDTH], r_acc[WIDTH-1]};
    w_diff = w_rsh - {1'b0, r_opnd};
    if (r_is_div) begin
      if (!w_diff[WIDTH]) w_step = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      else                w_step = {w_rsh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    end else begin
      w_step = {w_sum, r_acc[WIDTH-1:1]};
    end
  end

  // Load on go, then step WIDTH times; a zero divisor falls out as
  // quotient all-ones and remainder a without special casing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc    <= '0;
      r_opnd   <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b0;
      r_is_div <= 1'b0;
    end else if (go) begin
      r_acc    <= is_div ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
      r_opnd   <= is_div ? b : a;
      r_cnt    <= '0;
      r_run    <= 1'b1;
      r_is_div <= is_div;
    end else if (r_run) begin
      r_acc <= w_step;
      r_cnt <= r_cnt + 1'b1;
      if (last) r_run <= 1'b0;
    end
  end

  // acc_out is the value after this cycle's step, so it is final when last=1.
  assign acc_out = w_step;
  assign last    = r_run && (r_cnt == SHW'(WIDTH - 1));

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: start/busy/done handshake, single-cycle logic/arith ops,
// iterative MUL/DIV, optional invert/increment post-processing.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             output_inverted,
  input  logic             output_inc,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] res_high,
  output logic [WIDTH-1:0] res_low
);

  localparam int unsigned W2 = 2 * WIDTH;

  state_e           r_state;
  state_e           w_state_n;
  logic             r_inv;
  logic             r_inc;
  logic             r_is_div;
  logic             r_bz;
  logic             r_done;
  logic             r_dbz;
  logic [W2-1:0]    r_res;

  logic             w_latch;
  logic             w_go;
  logic             w_is_md;
  logic             w_fin_load;
  logic [W2-1:0]    w_fin_raw;
  logic             w_fin_inv;
  logic             w_fin_inc;
  logic [W2-1:0]    w_post;
  logic [W2-1:0]    w_sc_raw;
  logic [WIDTH:0]   w_add;
  logic [SHW-1:0]   w_sh;
  logic [W2-1:0]    w_rol2;
  logic [W2-1:0]    w_acc;
  logic             w_last;

  seq_alu_muldiv #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_muldiv (
    .clk     (clk),
    .rst     (rst),
    .go      (w_go),
    .is_div  (aluop == OpDiv),
    .a       (a),
    .b       (b),
    .acc_out (w_acc),
    .last    (w_last)
  );

  // Single-cycle ops, evaluated on the live operands in the start cycle.
  always_comb begin
    w_sh     = b[SHW-1:0];
    w_add    = {1'b0, a} + {1'b0, b};
    w_rol2   = {a, a} << w_sh;
    w_sc_raw = '0;
    case (aluop)
      OpAdd: w_sc_raw = {{(WIDTH-1){1'b0}}, w_add[WIDTH], w_add[WIDTH-1:0]};
      OpSub: w_sc_raw = {{WIDTH{(a < b)}}, a - b};
      OpAnd: w_sc_raw = {{WIDTH{1'b0}}, a & b};
      OpOr:  w_sc_raw = {{WIDTH{1'b0}}, a | b};
      OpXor: w_sc_raw = {{WIDTH{1'b0}}, a ^ b};
      OpClo: w_sc_raw = {{WIDTH{1'b0}}, WIDTH'(clz_count(ClzMaxWidth'(~a), WIDTH))};
      OpClz: w_sc_raw = {{WIDTH{1'b0}}, WIDTH'(clz_count(ClzMaxWidth'(a), WIDTH))};
      OpSll: w_sc_raw = {{WIDTH{1'b0}}, a << w_sh};
      OpSrl: w_sc_raw = {{WIDTH{1'b0}}, a >> w_sh};
      OpSra: w_sc_raw = {{WIDTH{1'b0}}, WIDTH'($signed(a) >>> w_sh)};
      OpRol: w_sc_raw = {{WIDTH{1'b0}}, w_rol2[W2-1:WIDTH]};
      default: w_sc_raw = '0;
    endcase
  end

  // Next state, operand latch strobes and selection of the result to register.
  always_comb begin
    w_state_n  = r_state;
    w_latch    = 1'b0;
    w_go       = 1'b0;
    w_fin_load = 1'b0;
    w_fin_raw  = w_sc_raw;
    w_fin_inv  = output_inverted;
    w_fin_inc  = output_inc;
    w_is_md    = (aluop == OpMul) || (aluop == OpDiv);
    case (r_state)
      StIdle: begin
        if (start) begin
          w_latch = 1'b1;
          if (w_is_md) begin
            w_go      = 1'b1;
            w_state_n = StCalc;
          end else begin
            w_fin_load = 1'b1;
            w_state_n  = StFin;
          end
        end
      end
      StCalc: begin
        if (w_last) begin
          w_fin_load = 1'b1;
          w_fin_raw  = w_acc;
          w_fin_inv  = r_inv;
          w_fin_inc  = r_inc;
          w_state_n  = StFin;
        end
      end
      StFin:   w_state_n = StIdle;
      default: w_state_n = StIdle;
    endcase
  end

  // Post-processing, modulo 2^(2*WIDTH).
  always_comb begin
    w_post = (w_fin_inv ? ~w_fin_raw : w_fin_raw) + W2'(w_fin_inc);
  end

  // State, latched options and result registers; results land as FIN is entered
  // so they are valid in the same cycle as done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= StIdle;
      r_inv    <= 1'b0;
      r_inc    <= 1'b0;
      r_is_div <= 1'b0;
      r_bz     <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_res    <= '0;
    end else begin
      r_state <= w_state_n;
      r_done  <= w_fin_load;
      if (w_latch) begin
        r_inv    <= output_inverted;
        r_inc    <= output_inc;
        r_is_div <= (aluop == OpDiv);
        r_bz     <= (b == '0);
        r_dbz    <= 1'b0;
      end else if (w_fin_load) begin
        r_dbz <= r_is_div && r_bz;
      end
      if (w_fin_load) r_res <= w_post;
    end
  end

  assign busy        = (r_state != StIdle);
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign res_high    = r_res[W2-1:WIDTH];
  assign res_low     = r_res[WIDTH-1:0];

endmodule
